// File: rtl/sel_op_pkg.sv
// Shared opcode encoding and constant helpers for the select/operate pipeline.
package sel_op_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'd0,
    OP_INC  = 3'd1,
    OP_INV  = 3'd2,
    OP_SEL  = 3'd3,
    OP_ACC  = 3'd4,
    OP_ADDK = 3'd5
  } op_e;

  // Callers size-cast the result to their own width, which sign-extends or truncates.
  function automatic int sext_offset(input logic signed [7:0] off);
    return int'(off);
  endfunction

endpackage

// File: rtl/sel_op_alu.sv
// Combinational op evaluation for stage 2 of sel_op_pipe.
// SEL_OP_PIPE_SAT_EN selects saturating ADD/INC/ACC/ADDK instead of modular wrap.
module sel_op_alu
  import sel_op_pkg::*;
#(
  parameter int                 WIDTH  = 8,
  parameter logic signed [7:0]  OFFSET = 8'sd64
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  input  logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] result,
  output logic             flag
);

  localparam logic [WIDTH-1:0] K       = WIDTH'(sext_offset(OFFSET));
  localparam logic [WIDTH-1:0] SMAX    = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN    = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] addend;
  logic             ovf;

  always_comb begin
    result = '0;
    flag   = 1'b0;
    addend = '0;
    sum    = '0;
    ovf    = 1'b0;
    case (op_e'(op))
      OP_ADD, OP_INC, OP_ACC: begin
        case (op_e'(op))
          OP_ADD:  addend = b;
          OP_INC:  addend = WIDTH'(1);
          default: addend = acc;
        endcase
        sum = {1'b0, a} + {1'b0, addend};
`ifdef SEL_OP_PIPE_SAT_EN
        result = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
        result = sum[WIDTH-1:0];
`endif
        flag = sum[WIDTH];
      end
      OP_INV: result = ~a;
      OP_SEL: result = sel ? a : b;
      OP_ADDK: begin
        sum = {1'b0, a} + {1'b0, K};
        // Signed overflow: operands agree in sign, sum does not.
        ovf = (a[WIDTH-1] == K[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
`ifdef SEL_OP_PIPE_SAT_EN
        result = ovf ? (a[WIDTH-1] ? SMIN : SMAX) : sum[WIDTH-1:0];
`else
        result = sum[WIDTH-1:0];
`endif
        flag = ovf;
      end
      default: begin
        result = '0;
        flag   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/sel_op_pipe.sv
// Two-stage valid/ready select/operate pipeline with accumulator.
// Define SEL_OP_PIPE_SAT_EN for saturating arithmetic (see sel_op_alu).
module sel_op_pipe
  import sel_op_pkg::*;
#(
  parameter int                WIDTH  = 8,
  parameter logic signed [7:0] OFFSET = 8'sd64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag
);

  logic             s1_valid, s2_valid, s2_adv;
  logic [OP_W-1:0]  s1_op;
  logic [WIDTH-1:0] s1_a, s1_b, acc, acc_in, alu_result;
  logic             s1_sel, alu_flag;

  assign s2_adv    = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_adv;
  assign out_valid = s2_valid;
  // A coincident clear zeroes the operand so the ACC result starts fresh from a.
  assign acc_in    = acc_clr ? '0 : acc;

  sel_op_alu #(.WIDTH(WIDTH), .OFFSET(OFFSET)) u_alu (
    .op     (s1_op),
    .a      (s1_a),
    .b      (s1_b),
    .sel    (s1_sel),
    .acc    (acc_in),
    .result (alu_result),
    .flag   (alu_flag)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_sel   <= 1'b0;
      s2_valid <= 1'b0;
      result   <= '0;
      flag     <= 1'b0;
      acc      <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_op  <= op;
          s1_a   <= a;
          s1_b   <= b;
          s1_sel <= sel;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          result <= alu_result;
          flag   <= alu_flag;
        end
      end
      if (acc_clr)
        acc <= '0;
      if (s2_adv && s1_valid && (op_e'(s1_op) == OP_ACC))
        acc <= alu_result;
    end
  end

endmodule

// File: tb/tb_sel_op_pipe.sv
// Self-checking bench for sel_op_pipe: directed cases plus randomized traffic vs a queue model.
module tb_sel_op_pipe;
  localparam int W    = 8;
  localparam int M    = (1 << W) - 1;
  localparam int SMAX = M / 2;
  localparam int SMIN = -(M / 2) - 1;
  localparam int KOFF = 64;

  logic         clk = 1'b0, rst = 1'b0;
  logic         in_valid = 1'b0, sel = 1'b0, acc_clr = 1'b0, out_ready = 1'b0;
  logic         in_ready, out_valid, flag;
  logic [2:0]   op = '0;
  logic [W-1:0] a = '0, b = '0, result;

  always #5 clk = ~clk;

  sel_op_pipe #(.WIDTH(W), .OFFSET(8'sd64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .sel(sel), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .flag(flag)
  );

  typedef struct { int r; int f; int cyc; } exp_t;
  exp_t q[$];
  exp_t e;
  int   n_cmp = 0, n_bad = 0, cyc = 0, mdl_acc = 0;
  bit   lat_chk = 0, next_clr = 0, lit_on = 0;
  int   lit_r = 0, lit_f = 0;
  bit   held = 0;
  int   held_r = 0, held_f = 0;

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Reference arithmetic done on plain integers with explicit range checks.
  function automatic void model(input int o, input int x, input int y, input int s,
                                input bit clr, output int r, output int f);
    int sum, sx, ss;
    r = 0; f = 0;
    case (o)
      0, 1, 4: begin
        if (o == 0)      sum = x + y;
        else if (o == 1) sum = x + 1;
        else             sum = (clr ? 0 : mdl_acc) + x;
`ifdef SEL_OP_PIPE_SAT_EN
        r = (sum > M) ? M : sum;
`else
        r = sum & M;
`endif
        f = (sum > M) ? 1 : 0;
        if (o == 4) mdl_acc = r;
      end
      2: r = (~x) & M;
      3: r = s ? x : y;
      5: begin
        sx = (x > SMAX) ? x - (M + 1) : x;
        ss = sx + KOFF;
        f  = (ss > SMAX || ss < SMIN) ? 1 : 0;
`ifdef SEL_OP_PIPE_SAT_EN
        r = (ss > SMAX) ? SMAX : ((ss < SMIN) ? (SMIN & M) : (ss & M));
`else
        r = ss & M;
`endif
      end
      default: begin r = 0; f = 0; end
    endcase
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
      held    = 0;
      mdl_acc = 0;
    end else begin
      if (out_valid) begin
        if (held) begin
          chk("hold_result", int'(result), held_r);
          chk("hold_flag", int'(flag), held_f);
        end
        if (out_ready) begin
          if (q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL spurious_out: got result %0h, expected no beat", result);
          end else begin
            e = q.pop_front();
            chk("result", int'(result), e.r);
            chk("flag", int'(flag), e.f);
            if (lat_chk) chk("latency", cyc - e.cyc, 2);
          end
        end
      end
      held   = out_valid && !out_ready;
      held_r = int'(result);
      held_f = int'(flag);
      if (in_valid && in_ready) begin
        model(int'(op), int'(a), int'(b), int'(sel), next_clr, e.r, e.f);
        e.cyc = cyc;
        q.push_back(e);
        if (lit_on) begin
          chk("model_lit_result", e.r, lit_r);
          chk("model_lit_flag", e.f, lit_f);
        end
        next_clr = 0;
      end
    end
  end

  task automatic send(input int o, input int x, input int y, input int s,
                      input int er, input int ef);
    bit ok;
    op = 3'(o); a = W'(x); b = W'(y); sel = s[0];
    lit_r = er; lit_f = ef; lit_on = 1; in_valid = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1;
      if (ok) begin in_valid = 0; lit_on = 0; return; end
    end
    n_cmp++; n_bad++;
    $display("FAIL send_timeout: got no accept, expected accept within 50 cycles");
    in_valid = 0; lit_on = 0;
  endtask

  task automatic drain();
    in_valid = 0; out_ready = 1;
    for (int i = 0; i < 30 && q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    int nacc, idx;
    bit take;
    rst = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1;
    @(posedge clk); #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_flag", int'(flag), 0);
    chk("rst_in_ready", int'(in_ready), 1);

    out_ready = 1; lat_chk = 1;
    send(0, 'h10, 'h20, 0, 'h30, 0);
`ifdef SEL_OP_PIPE_SAT_EN
    send(0, 'hFF, 'h01, 0, 'hFF, 1);
`else
    send(0, 'hFF, 'h01, 0, 'h00, 1);
`endif
    send(1, 'h7F, 0, 0, 'h80, 0);
    send(2, 'h0F, 0, 0, 'hF0, 0);
    send(3, 'h01, 'h09, 0, 'h09, 0);
    send(5, 'h10, 0, 0, 'h50, 0);
    send(4, 3, 0, 0, 3, 0);
    send(4, 4, 0, 0, 7, 0);
    send(4, 5, 0, 0, 12, 0);
    next_clr = 1;
    send(4, 2, 0, 0, 2, 0);
    acc_clr = 1;
    @(posedge clk); #1 acc_clr = 0;
    send(4, 1, 0, 0, 3, 0);
`ifdef SEL_OP_PIPE_SAT_EN
    send(5, 'h50, 0, 0, 'h7F, 1);
`else
    send(5, 'h50, 0, 0, 'h90, 1);
`endif
    drain();

    // Backpressure: four beats offered while the consumer stalls.
    lat_chk = 0; out_ready = 0; nacc = 0; idx = 0;
    op = 3'd0; a = W'(8'h11); b = W'(1); in_valid = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); take = in_ready; if (take) nacc++;
      @(posedge clk); #1;
      if (take) begin idx++; a = W'(idx * 'h11 + 'h11); end
    end
    chk("bp_accepted", nacc, 2);
    chk("bp_in_ready", int'(in_ready), 0);
    out_ready = 1;
    for (int c = 0; c < 20 && nacc < 4; c++) begin
      @(negedge clk); take = in_ready; if (take) nacc++;
      @(posedge clk); #1;
      if (take) begin idx++; a = W'(idx * 'h11 + 'h11); end
    end
    in_valid = 0;
    chk("bp_total", nacc, 4);
    drain();

    // Reset while beats are in flight.
    out_ready = 1;
    send(0, 1, 2, 0, 3, 0);
    send(1, 5, 0, 0, 6, 0);
    out_ready = 0;
    chk("pre_rst_valid", int'(out_valid), 1);
    #2 rst = 0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_result", int'(result), 0);
    chk("midrst_flag", int'(flag), 0);
    repeat (2) @(posedge clk);
    #2 rst = 1;
    @(posedge clk); #1;
    chk("postrst_in_ready", int'(in_ready), 1);
    chk("postrst_out_valid", int'(out_valid), 0);

    // Randomized traffic with random stalls.
    for (int c = 0; c < 1500; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      op        = 3'($urandom_range(0, 7));
      a         = ($urandom_range(0, 7) == 0) ? W'(M) : W'($urandom);
      b         = ($urandom_range(0, 7) == 0) ? W'(M) : W'($urandom);
      sel       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish before limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sel_op_pipe.md
Name: sel_op_pipe

Overview:
- Parametrised successor to the team's single-cycle select/operate datapath.
- Two-stage pipelined operation unit: operands A/B plus an opcode in, registered result out.
- Valid/ready handshake on both sides with full backpressure.
- Adds accumulator mode, signed constant-offset mode and a carry/overflow flag.
- Sits between an operand source and a result consumer in the datapath.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- OFFSET, signed 8-bit, 64: constant for op ADDK, sign-extended (or truncated) to WIDTH.
- OP_W, 3: opcode width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit accepts a beat this cycle.
- op  in  OP_W  opcode.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sel  in  1  mux select for op SEL.
- acc_clr  in  1  synchronous accumulator clear.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  operation result.
- flag  out  1  carry-out (wrap mode) or saturation hit (SAT mode).

Behaviour:
- Reset (rst=0, async): s1_valid=0, s2_valid=0, out_valid=0, result=0, flag=0, acc=0. in_ready=1 from the first cycle after reset release.
- Transfer: a beat moves on a cycle where valid&&ready. Skip-free pipeline, no combinational path valid->valid.
- Stall logic: s2_adv = !s2_valid || out_ready; in_ready = !s1_valid || s2_adv.
- Stage 1 registers op, a, b and sel on input transfer.
- Stage 2 computes and registers result/flag when s1_valid && s2_adv.
- Latency: exactly 2 cycles input transfer -> out_valid when unstalled. Throughput 1 beat/cycle.
- While out_valid=1 && out_ready=0, result/flag hold stable and no beat is lost or duplicated.
- Ops, computed in WIDTH+1 bits; flag = bit WIDTH unless stated:
  - 0 ADD: a+b.
  - 1 INC: a+1.
  - 2 INV: ~a, flag=0.
  - 3 SEL: sel ? a : b, flag=0.
  - 4 ACC: acc+a; acc <= result (WIDTH bits) at the stage-2 update.
  - 5 ADDK: a + sext(OFFSET); flag = signed overflow.
  - 6, 7: result=0, flag=0.
- acc updates only at a stage-2 update carrying ACC.
- acc_clr=1 clears acc at the clock edge. If it coincides with a stage-2 ACC update, clear takes priority for the operand: result = a, and acc <= a.
- Wrap-around: ADD 0xFF+0x01 (WIDTH=8) -> result 0x00, flag=1.
- Reset mid-operation: all in-flight beats discarded, outputs return to reset values immediately.

Optional Feature:
- Macro: SEL_OP_PIPE_SAT_EN.
- Defined: ADD, INC and ACC saturate unsigned at 2^WIDTH-1. ADDK saturates signed at the max/min representable value. flag=1 when saturation occurred. acc stores the saturated value.
- Undefined: modular wrap; flag as carry/overflow per the op list.

Decomposition:
- Package sel_op_pkg holds:
  - op_e enum: OP_ADD, OP_INC, OP_INV, OP_SEL, OP_ACC, OP_ADDK.
  - OP_W constant.
  - function sext_offset().
- One natural sub-module: sel_op_alu, the purely combinational op evaluation (op, a, b, sel, acc -> result, flag) instantiated in stage 2. The pipeline, handshake and acc register stay in sel_op_pipe.

Test Plan:
- Reset then idle -> out_valid=0, result=0, flag=0, in_ready=1; assert rst mid-stream -> out_valid drops immediately.
- ADD a=0x10 b=0x20, out_ready=1 -> result 0x30, flag=0, out_valid exactly 2 cycles after accept; ADD 0xFF+0x01 -> 0x00, flag=1 (SAT build: 0xFF, flag=1).
- Back-to-back ops INC 0x7F, INV 0x0F, SEL sel=0 a=1 b=9, ADDK a=0x10 -> results 0x80, 0xF0, 0x09, 0x50 in order, one per cycle.
- ACC a=3, 4, 5 -> results 3, 7, 12; then acc_clr coincident with ACC a=2 -> result 2, next ACC a=1 -> 3.
- Backpressure: out_ready=0 for 5 cycles with 4 beats offered -> in_ready falls after 2 accepted, result stable; release -> all beats delivered in order, none lost.
- ADDK a=0x50 (OFFSET=64) -> 0x90, flag=1 (signed overflow); SAT build -> 0x7F, flag=1.
